// File: rtl/dsp_run_ctrl.sv
// Two-requester arbiter/sequencer for one dsp: loads config words, starts, runs, captures dout.
// Optional round-robin arbitration under `DSP_RUN_CTRL_RR_EN (default: fixed priority, req[0] wins).
module dsp_run_ctrl #(
    parameter int BUS_WIDTH  = 24,
    parameter int REG_COUNT  = 8,
    parameter int RUN_CYCLES = 201
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [1:0]           req,
    input  logic [7:0]           param0,
    input  logic [7:0]           param1,
    output logic [2:0]           cfg_addr,
    input  logic [BUS_WIDTH-1:0] cfg_rdata0,
    input  logic [BUS_WIDTH-1:0] cfg_rdata1,
    output logic [1:0]           gnt,
    output logic                 busy,
    output logic [1:0]           done,
    output logic [BUS_WIDTH-1:0] result,
    output logic                 dsp_en,
    output logic                 dsp_start,
    output logic [7:0]           dsp_param,
    output logic [2:0]           dsp_addr,
    output logic [BUS_WIDTH-1:0] dsp_din,
    output logic                 dsp_we,
    input  logic [BUS_WIDTH-1:0] dsp_dout
);
    localparam int WCW = (REG_COUNT  > 1) ? $clog2(REG_COUNT)  : 1;
    localparam int RCW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

    state_t         state;
    logic [WCW-1:0] wcnt;
    logic [RCW-1:0] rcnt;
    logic [1:0]     pick;

`ifdef DSP_RUN_CTRL_RR_EN
    // High means requester 1 was served last; reset value lets requester 0 win first.
    logic last_gnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            last_gnt <= 1'b1;
        else if (state == DONE)
            last_gnt <= gnt[1];
    end

    always_comb begin
        pick = req[0] ? 2'b01 : 2'b10;
        if (req == 2'b11)
            pick = last_gnt ? 2'b01 : 2'b10;
    end
`else
    always_comb begin
        pick = req[0] ? 2'b01 : 2'b10;
    end
`endif

    // wcnt is cleared on leaving LOAD, so the address reads 0 everywhere else.
    assign dsp_addr = 3'(wcnt);
    assign cfg_addr = dsp_addr;
    assign dsp_din  = dsp_we ? (gnt[1] ? cfg_rdata1 : cfg_rdata0) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            wcnt      <= '0;
            rcnt      <= '0;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            done      <= 2'b00;
            result    <= '0;
            dsp_en    <= 1'b0;
            dsp_start <= 1'b0;
            dsp_we    <= 1'b0;
            dsp_param <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt       <= pick;
                        dsp_param <= pick[1] ? param1 : param0;
                        wcnt      <= '0;
                        busy      <= 1'b1;
                        dsp_we    <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (wcnt == WCW'(REG_COUNT - 1)) begin
                        wcnt      <= '0;
                        dsp_we    <= 1'b0;
                        dsp_start <= 1'b1;
                        dsp_en    <= 1'b1;
                        state     <= START;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                START: begin
                    rcnt      <= RCW'(RUN_CYCLES - 1);
                    dsp_start <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    if (rcnt == '0) begin
                        dsp_en <= 1'b0;
                        done   <= gnt;
                        state  <= DONE;
                    end else begin
                        rcnt <= rcnt - 1'b1;
                    end
                end
                DONE: begin
                    result <= dsp_dout;
                    done   <= 2'b00;
                    gnt    <= 2'b00;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dsp_run_ctrl.sv
// Bench for dsp_run_ctrl: directed job table, hand sequences and random traffic vs a job-timeline model.
module tb_dsp_run_ctrl;
    localparam int BW = 24;
    localparam int RC = 8;
    localparam int RN = 4;
    localparam int DK = RC + RN + 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [7:0]    param0 = 8'h00, param1 = 8'h00;
    logic [2:0]    cfg_addr;
    logic [BW-1:0] cfg_rdata0, cfg_rdata1;
    logic [1:0]    gnt, done;
    logic          busy, dsp_en, dsp_start, dsp_we;
    logic [BW-1:0] result, dsp_din;
    logic [BW-1:0] dsp_dout = '0;
    logic [7:0]    dsp_param;
    logic [2:0]    dsp_addr;

    logic [BW-1:0] cfg0 [8];
    logic [BW-1:0] cfg1 [8];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb cfg_rdata0 = cfg0[cfg_addr];
    always_comb cfg_rdata1 = cfg1[cfg_addr];

    dsp_run_ctrl #(.BUS_WIDTH(BW), .REG_COUNT(RC), .RUN_CYCLES(RN)) dut (
        .clk(clk), .rstn(rstn), .req(req), .param0(param0), .param1(param1),
        .cfg_addr(cfg_addr), .cfg_rdata0(cfg_rdata0), .cfg_rdata1(cfg_rdata1),
        .gnt(gnt), .busy(busy), .done(done), .result(result),
        .dsp_en(dsp_en), .dsp_start(dsp_start), .dsp_param(dsp_param),
        .dsp_addr(dsp_addr), .dsp_din(dsp_din), .dsp_we(dsp_we), .dsp_dout(dsp_dout)
    );

    // Model: a job is just an owner plus its age k (cycles since the sampling edge).
    bit            m_busy;
    int            m_k, m_own, m_last;
    logic [7:0]    m_param;
    logic [BW-1:0] m_result;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_own = 0; m_last = 1; m_param = '0; m_result = '0;
    endtask

    function automatic int arbitrate(input logic [1:0] r);
        if (r == 2'b11) begin
`ifdef DSP_RUN_CTRL_RR_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return r[0] ? 0 : 1;
    endfunction

    task automatic model_step();
        if (!rstn) model_reset();
        else if (!m_busy) begin
            if (req != 2'b00) begin
                m_own = arbitrate(req);
                m_param = (m_own == 1) ? param1 : param0;
                m_busy = 1; m_k = 1;
            end
        end else if (m_k == DK) begin
            m_result = dsp_dout; m_last = m_own; m_busy = 0; m_k = 0;
        end else m_k++;
    endtask

    task automatic check_all();
        logic [1:0] eg;
        bit ld, st, en, dn;
        eg = !m_busy ? 2'b00 : (m_own == 1 ? 2'b10 : 2'b01);
        ld = m_busy && m_k <= RC;
        st = m_busy && m_k == RC + 1;
        en = m_busy && m_k >= RC + 1 && m_k <= RC + 1 + RN;
        dn = m_busy && m_k == DK;
        check("gnt", 32'(gnt), 32'(eg));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), dn ? 32'(eg) : 32'd0);
        check("dsp_we", 32'(dsp_we), 32'(ld));
        check("dsp_start", 32'(dsp_start), 32'(st));
        check("dsp_en", 32'(dsp_en), 32'(en));
        check("dsp_addr", 32'(dsp_addr), ld ? 32'(m_k - 1) : 32'd0);
        check("cfg_addr", 32'(cfg_addr), ld ? 32'(m_k - 1) : 32'd0);
        check("dsp_param", 32'(dsp_param), 32'(m_param));
        check("result", 32'(result), 32'(m_result));
        if (ld) check("dsp_din", 32'(dsp_din), 32'(m_own == 1 ? cfg1[m_k - 1] : cfg0[m_k - 1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Ticks until done is seen (bounded); lat counts cycles after the sampling edge.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            lat++;
            if (done != 2'b00) break;
        end
    endtask

    typedef struct {
        logic [1:0]    req;
        logic [7:0]    p0, p1;
        logic [BW-1:0] dout;
        logic [1:0]    exp_gnt;
        logic [7:0]    exp_param;
        int            exp_lat;
    } vec_t;

    vec_t tbl [5];
    int   lat;
    logic [1:0] g1;

    initial begin
        for (int i = 0; i < 8; i++) begin
            cfg0[i] = BW'($urandom);
            cfg1[i] = BW'($urandom);
        end
        tbl[0] = '{2'b01, 8'h5A, 8'h11, 24'h00ABCD, 2'b01, 8'h5A, DK};
        tbl[1] = '{2'b10, 8'h22, 8'hC3, 24'h123456, 2'b10, 8'hC3, DK};
        tbl[2] = '{2'b01, 8'h77, 8'h88, 24'hFFFFFF, 2'b01, 8'h77, DK};
`ifdef DSP_RUN_CTRL_RR_EN
        tbl[3] = '{2'b11, 8'h01, 8'h02, 24'h000001, 2'b10, 8'h02, DK};
`else
        tbl[3] = '{2'b11, 8'h01, 8'h02, 24'h000001, 2'b01, 8'h01, DK};
`endif
        tbl[4] = '{2'b11, 8'hA0, 8'hB0, 24'h000000, 2'b01, 8'hA0, DK};

        model_reset();
        #1;
        check_all();
        tick(); tick();
        rstn = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            req = tbl[v].req; param0 = tbl[v].p0; param1 = tbl[v].p1; dsp_dout = tbl[v].dout;
            tick();
            check("tbl_gnt", 32'(gnt), 32'(tbl[v].exp_gnt));
            check("tbl_param", 32'(dsp_param), 32'(tbl[v].exp_param));
            param0 = 8'h00; param1 = 8'h00;
            wait_done(lat);
            check("tbl_lat", 32'(lat + 1), 32'(tbl[v].exp_lat));
            req = 2'b00;
            tick();
            check("tbl_result", 32'(result), 32'(tbl[v].dout));
            tick();
        end

        // Back-to-back with both requesting: exactly one IDLE cycle between jobs.
        rstn = 1'b0; #1; model_reset(); check_all();
        tick(); rstn = 1'b1; tick();
        req = 2'b11; param0 = 8'h10; param1 = 8'h20; dsp_dout = 24'h0C0FFE;
        tick();
        g1 = gnt;
        wait_done(lat);
        tick();
        check("b2b_idle", 32'(busy), 32'd0);
        tick();
        check("b2b_first", 32'(g1), 32'(2'b01));
`ifdef DSP_RUN_CTRL_RR_EN
        check("b2b_second", 32'(gnt), 32'(2'b10));
`else
        check("b2b_second", 32'(gnt), 32'(2'b01));
`endif
        wait_done(lat);
        check("b2b_lat", 32'(lat + 1), 32'(DK));
        req = 2'b00;
        tick(); tick();

        // Late request from requester 1 waits for requester 0's job.
        req = 2'b01; tick();
        for (int i = 0; i < RC + 2; i++) tick();
        req = 2'b11;
        wait_done(lat);
        check("late_done", 32'(done), 32'(2'b01));
        req = 2'b10;
        tick();
        check("late_idle_gnt", 32'(gnt), 32'd0);
        tick();
        check("late_gnt", 32'(gnt), 32'(2'b10));
        check("late_we", 32'(dsp_we), 32'd1);
        wait_done(lat);
        req = 2'b00;
        tick(); tick();

        // Asynchronous reset in RUN: outputs clear before any clock edge, no done.
        req = 2'b01; dsp_dout = 24'h5555AA; tick();
        for (int i = 0; i < RC + 3; i++) tick();
        #2 rstn = 1'b0;
        #1 model_reset();
        check_all();
        check("rst_busy", 32'(busy), 32'd0);
        req = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        rstn = 1'b1;
        tick();
        req = 2'b10; tick();
        wait_done(lat);
        check("rst_relat", 32'(lat + 1), 32'(DK));
        req = 2'b00; tick(); tick();

        // Requester drops req during LOAD; job still completes.
        req = 2'b01; tick();
        tick(); tick(); tick();
        req = 2'b00;
        wait_done(lat);
        check("drop_done", 32'(done), 32'(2'b01));
        check("drop_lat", 32'(lat + 4), 32'(DK));
        tick();

        for (int i = 0; i < 400; i++) begin
            req = 2'($urandom_range(0, 3));
            param0 = 8'($urandom); param1 = 8'($urandom);
            dsp_dout = BW'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dsp_run_ctrl.md
Name: dsp_run_ctrl

Overview:
- Sequencer and arbiter in front of a single dsp instance, shared between two requesters.
- Grants one requester and streams that requester's configuration words into the dsp register file.
- Pulses start, keeps the dsp enabled for a fixed run length, then captures dout as the result and hands it back with a one-cycle done pulse.

Parameters:
- BUS_WIDTH, 24: width of the dsp din/dout words and of the result.
- REG_COUNT, 8: number of config words written per job, at dsp addresses 0..REG_COUNT-1. Legal range 1..8.
- RUN_CYCLES, 201: cycles dsp_en stays high after start before dout is sampled. Must be at least 1.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- rstn  in  1  asynchronous active-low reset.
- req  in  2  request per requester; held high until matching done.
- param0  in  8  requester 0 dsp param.
- param1  in  8  requester 1 dsp param.
- cfg_addr  out  3  config word index presented to both requesters.
- cfg_rdata0  in  BUS_WIDTH  requester 0 config word at cfg_addr, combinational.
- cfg_rdata1  in  BUS_WIDTH  requester 1 config word at cfg_addr, combinational.
- gnt  out  2  one-hot grant, 0 when idle.
- busy  out  1  high in any state other than IDLE.
- done  out  2  one-cycle completion pulse to the granted requester.
- result  out  BUS_WIDTH  captured dsp dout, held until the next capture.
- dsp_en  out  1  to dsp en.
- dsp_start  out  1  to dsp start.
- dsp_param  out  8  to dsp param; latched at grant.
- dsp_addr  out  3  to dsp addr.
- dsp_din  out  BUS_WIDTH  to dsp din.
- dsp_we  out  1  to dsp we.
- dsp_dout  in  BUS_WIDTH  from dsp dout.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE. gnt, done, busy, dsp_en, dsp_start, dsp_we, dsp_addr, dsp_param, result and internal counters all 0.
- State machine IDLE -> LOAD -> START -> RUN -> DONE -> IDLE.
- IDLE:
  - If req != 0 at a clock edge: latch grant per arbitration, latch dsp_param from the granted requester's param, clear word counter, go to LOAD.
  - If req == 0, stay.
- LOAD (REG_COUNT cycles):
  - cfg_addr = dsp_addr = word counter.
  - dsp_we = 1; dsp_din = cfg_rdata of the granted requester (combinational mux).
  - Counter increments each cycle. After the cycle with counter = REG_COUNT-1, go to START.
- START (1 cycle):
  - dsp_start = 1, dsp_en = 1.
  - Run counter loads RUN_CYCLES-1. Go to RUN.
- RUN:
  - dsp_en = 1. Run counter decrements each cycle.
  - After the cycle with counter = 0, go to DONE. RUN therefore lasts exactly RUN_CYCLES cycles.
- DONE (1 cycle):
  - result <= dsp_dout at the end of the cycle.
  - done[granted] = 1 for this cycle only; gnt is still asserted.
  - Next state IDLE; gnt clears on entry to IDLE.
- Outside LOAD: dsp_we = 0 and cfg_addr = 0. Outside START/RUN: dsp_en = 0.
- Latency: req sampled at edge E. LOAD occupies E+1..E+REG_COUNT, START is E+REG_COUNT+1, DONE is E+REG_COUNT+RUN_CYCLES+2.
- Arbitration:
  - Only evaluated in IDLE.
  - Requests arriving mid-job wait.
  - A req deasserted mid-job does not abort; the job completes and done still pulses.
- A requester holding req high across done is re-eligible in the first IDLE cycle.
- Back-to-back jobs have exactly 1 IDLE cycle between DONE and the next LOAD.
- Reset mid-job returns to IDLE immediately. No done pulse; result is cleared.
- Counter widths are sized internally from REG_COUNT and RUN_CYCLES (clog2). No wrap occurs in legal configurations.

Optional Feature:
- Macro: DSP_RUN_CTRL_RR_EN.
- Defined: round-robin arbitration. A last-grant register (reset to 1, so requester 0 wins first) is updated in DONE. When both req bits are high, the grant goes to the requester not served last.
- Undefined: fixed priority; req[0] always wins when both are high. No last-grant register exists.

Test Plan:
- Reset, then req=2'b01, param0=8'h5A, REG_COUNT=8, RUN_CYCLES=4 -> dsp_we high for 8 cycles with dsp_addr 0..7 and dsp_din = cfg_rdata0, dsp_param=8'h5A, a single dsp_start pulse, dsp_en high for 5 cycles, done=2'b01 exactly 14 cycles after the sampling edge.
- dsp_dout=24'h00ABCD during DONE -> result=24'h00ABCD afterwards, held through the next job's LOAD.
- req=2'b11 held for two jobs -> with DSP_RUN_CTRL_RR_EN the grants are 01 then 10; without it they are 01 then 01.
- req[1] asserted during requester 0's RUN -> no effect until IDLE; requester 1's LOAD starts 1 cycle after requester 0's DONE.
- rstn pulsed low during RUN -> all outputs 0 asynchronously, no done, FSM restarts cleanly on the next req.
- req[0] dropped during LOAD -> job completes and done[0] still pulses.
